ulm_sequencer: RTL and testbench
================================

Name: ulm_sequencer

Overview:
- Control FSM for the ULM core. Sequences each instruction through fetch, decode, execute, optional bus/IO wait, and retire.
- Drives the instruction-register load, the decoder enable and the execute strobe.
- Decides the PC update: step or jump.
- Handles halt, blocking fault timeout and single-step.
- Sits between the PC/IR datapath, the instruction decoder, and the bus and IO units.

Parameters:
- TIMEOUT, 256, max cycles spent in FETCH or WAIT_BUS before FAULT; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  out  1  instruction fetch request to the bus.
- mem_ready  in  1  fetch data valid this cycle (1-cycle pulse).
- ir_load  out  1  load IR from fetch data this cycle.
- dec_en  out  1  decoder enable; the decoder registers its outputs on this edge.
- exec_en  out  1  1-cycle strobe; ALU/bus/CU/IO units act on the decoded instruction.
- is_halt  in  1  decoded instruction is a halt (valid in EXEC).
- is_bus  in  1  decoded instruction is a fetch/store (valid in EXEC).
- is_io  in  1  decoded instruction is putc/getc (valid in EXEC).
- jmp_taken  in  1  decoded CU op is a relative or absolute jump (valid in EXEC, held until RETIRE).
- bus_done  in  1  data bus transfer completed (pulse).
- io_done  in  1  IO transfer completed (pulse).
- step_mode  in  1  pause after each retired instruction.
- step  in  1  resume from PAUSE (pulse).
- pc_step  out  1  PC <= PC+4.
- pc_jmp  out  1  PC <= jump target.
- retired  out  CNT_W  retired-instruction count.
- halted  out  1  core stopped; sticky.
- fault  out  1  stopped by timeout; sticky.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encoding:
  - FETCH=0, DECODE=1, EXEC=2, WAIT_BUS=3, WAIT_IO=4, RETIRE=5, PAUSE=6, STOP=7.
  - STOP with fault=0 is a halt; STOP with fault=1 is a fault.
- Reset (async):
  - state=FETCH, timeout counter=0, retired=0, halted=0, fault=0.
  - Every output is 0 while rst=1; fetch_req is 0 during reset.
  - First fetch_req=1 occurs in the first cycle after rst deasserts.
- Outputs are decoded from state (Moore), except ir_load.
- FETCH:
  - fetch_req=1.
  - ir_load = mem_ready (Mealy).
  - On mem_ready -> DECODE.
  - Otherwise the counter increments; when the counter == TIMEOUT-1 (TIMEOUT≠0) and mem_ready=0 -> STOP with fault=1.
- DECODE: dec_en=1 for exactly one cycle -> EXEC.
- EXEC: exec_en=1 for exactly one cycle. Next-state priority:
  - is_halt -> STOP, halted=1.
  - else is_bus -> WAIT_BUS.
  - else is_io -> WAIT_IO.
  - else -> RETIRE.
- WAIT_BUS:
  - bus_done -> RETIRE.
  - Same timeout rule as FETCH -> STOP with fault=1.
- WAIT_IO: io_done -> RETIRE. No timeout, because getc may block indefinitely.
- Counter clear: the timeout counter clears on every entry into FETCH or WAIT_BUS.
- A done/ready pulse arriving in the same cycle the counter hits TIMEOUT-1 wins; no fault is raised.
- RETIRE:
  - Exactly one of pc_jmp (jmp_taken=1) or pc_step (jmp_taken=0) is 1, for one cycle.
  - retired increments modulo 2^CNT_W; it wraps to 0.
  - Next state: step_mode=1 -> PAUSE, else -> FETCH.
- PAUSE:
  - step=1 -> FETCH.
  - step_mode dropping to 0 also -> FETCH.
  - Stray step pulses in any other state are ignored.
- STOP:
  - halted=1, sticky; only rst leaves STOP.
  - fault=1 only for a timeout stop.
  - All strobes are 0; retired is frozen.
  - mem_ready, bus_done and io_done are ignored.
- Halt instruction: it is not counted in retired, and the PC is not updated.
- Minimum latencies:
  - Non-memory instruction: 4 cycles (FETCH with immediate mem_ready, DECODE, EXEC, RETIRE).
  - Bus instruction: ≥5 cycles.
- Reset asserted mid-instruction aborts immediately.
  - No partial RETIRE strobe is emitted.
  - The PC is owned by the datapath; its reset is external.

Test Plan:
- Release reset with mem_ready on the 1st FETCH cycle and decoder inputs all 0 -> sequence fetch_req, dec_en, exec_en, pc_step in 4 consecutive cycles; retired=1; fetch_req again in cycle 5.
- Bus instruction (is_bus=1) with bus_done after 3 cycles in WAIT_BUS -> pc_step exactly once, 1 cycle after bus_done; 7 cycles total.
- jmp_taken=1 in EXEC -> pc_jmp=1 and pc_step=0 in RETIRE. Then is_halt=1 on the next instruction -> halted=1, retired=1 (counts only the jump), no strobes for 20 further cycles despite mem_ready pulses.
- TIMEOUT=8, mem_ready held 0 -> fault=1 and halted=1 at the 8th FETCH cycle. A second run with mem_ready arriving on that exact 8th cycle -> DECODE, no fault.
- step_mode=1 -> PAUSE after each RETIRE; step pulse -> next fetch_req one cycle later; step pulse during EXEC has no effect.
- CNT_W=4, 16 retires -> retired wraps to 0. Assert rst mid-WAIT_IO -> all outputs 0 asynchronously, state_o=0 after release.

Source files
------------

// File: rtl/ulm_sequencer.sv
// Instruction sequencer for the ULM core: fetch, decode, execute, optional
// bus/IO wait, retire, plus halt, single-step pause and fetch/bus timeout.
module ulm_sequencer #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_req,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             dec_en,
    output logic             exec_en,
    input  logic             is_halt,
    input  logic             is_bus,
    input  logic             is_io,
    input  logic             jmp_taken,
    input  logic             bus_done,
    input  logic             io_done,
    input  logic             step_mode,
    input  logic             step,
    output logic             pc_step,
    output logic             pc_jmp,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_WAIT_BUS = 3'd3,
        S_WAIT_IO  = 3'd4,
        S_RETIRE   = 3'd5,
        S_PAUSE    = 3'd6,
        S_STOP     = 3'd7
    } state_t;

    localparam bit                TO_EN   = (TIMEOUT > 0);
    localparam int                TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_reg, state_next;
    logic [TO_W-1:0]  tmo_reg, tmo_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic             fault_reg, fault_next;
    logic             timeout_hit;

    // The counter is only meaningful in FETCH and WAIT_BUS; a ready/done
    // pulse on the last allowed cycle takes priority over the timeout.
    assign timeout_hit = TO_EN && (tmo_reg == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            tmo_reg     <= '0;
            retired_reg <= '0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_reg     <= tmo_next;
            retired_reg <= retired_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        unique case (state_reg)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_STOP;
                    fault_next = 1'b1;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_halt)      state_next = S_STOP;
                else if (is_bus)  state_next = S_WAIT_BUS;
                else if (is_io)   state_next = S_WAIT_IO;
                else              state_next = S_RETIRE;
            end
            S_WAIT_BUS: begin
                if (bus_done) begin
                    state_next = S_RETIRE;
                end else if (timeout_hit) begin
                    state_next = S_STOP;
                    fault_next = 1'b1;
                end
            end
            S_WAIT_IO: begin
                if (io_done) state_next = S_RETIRE;
            end
            S_RETIRE: state_next = step_mode ? S_PAUSE : S_FETCH;
            S_PAUSE: begin
                if (step || !step_mode) state_next = S_FETCH;
            end
            S_STOP:  state_next = S_STOP;
            default: state_next = S_STOP;
        endcase
    end

    // Any state change clears the counter, so every entry into FETCH or
    // WAIT_BUS starts counting from zero.
    always_comb begin
        if (state_next != state_reg) tmo_next = '0;
        else                         tmo_next = tmo_reg + 1'b1;
    end

    always_comb begin
        retired_next = retired_reg;
        if (state_reg == S_RETIRE) retired_next = retired_reg + 1'b1;
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign fetch_req = !rst && (state_reg == S_FETCH);
    assign ir_load   = fetch_req && mem_ready;
    assign dec_en    = !rst && (state_reg == S_DECODE);
    assign exec_en   = !rst && (state_reg == S_EXEC);
    assign pc_step   = !rst && (state_reg == S_RETIRE) && !jmp_taken;
    assign pc_jmp    = !rst && (state_reg == S_RETIRE) && jmp_taken;
    assign halted    = !rst && (state_reg == S_STOP);
    assign fault     = !rst && fault_reg;
    assign retired   = rst ? '0 : retired_reg;
    assign state_o   = rst ? 3'd0 : state_reg;

endmodule

// File: tb/tb_ulm_sequencer.sv
// Randomised scoreboard bench for ulm_sequencer (TIMEOUT=8, CNT_W=4).
module tb_ulm_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req, mem_ready, ir_load, dec_en, exec_en;
    logic       is_halt, is_bus, is_io, jmp_taken, bus_done, io_done;
    logic       step_mode, step, pc_step, pc_jmp, halted, fault;
    logic [3:0] retired;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    ulm_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .mem_ready(mem_ready),
        .ir_load(ir_load), .dec_en(dec_en), .exec_en(exec_en),
        .is_halt(is_halt), .is_bus(is_bus), .is_io(is_io), .jmp_taken(jmp_taken),
        .bus_done(bus_done), .io_done(io_done), .step_mode(step_mode), .step(step),
        .pc_step(pc_step), .pc_jmp(pc_jmp), .retired(retired), .halted(halted),
        .fault(fault), .state_o(state_o)
    );

    typedef struct {
        bit       jmp;
        bit [3:0] cnt;
    } exp_t;

    exp_t     sb[$];
    bit [3:0] model_cnt;
    int       tests_run = 0;
    int       fails = 0;
    int       cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every retire strobe consumes one expected retirement.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (pc_step || pc_jmp)) begin
            if (sb.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL unexpected_retire: step=%0b jmp=%0b, expected no retire", pc_step, pc_jmp);
            end else begin
                e = sb.pop_front();
                chk("retire_jmp", 32'(pc_jmp), 32'(e.jmp));
                chk("retire_step", 32'(pc_step), 32'(!e.jmp));
                chk("retire_cnt", 32'(retired), 32'(e.cnt));
                $display("[TB] retire jmp=%0b count_before=%0d", pc_jmp, retired);
            end
        end
    end

    task automatic clr_inputs();
        mem_ready = 0; is_halt = 0; is_bus = 0; is_io = 0; jmp_taken = 0;
        bus_done = 0; io_done = 0; step = 0;
    endtask

    // Asserts reset mid-cycle, checks outputs are low immediately, then
    // releases on a negedge so the caller sits in the first FETCH cycle.
    task automatic do_reset();
        #2 rst = 1;
        mem_ready = 1; bus_done = 1; io_done = 1; jmp_taken = 1;
        #1;
        chk("rst_fetch_req", 32'(fetch_req), 0);
        chk("rst_ir_load", 32'(ir_load), 0);
        chk("rst_strobes", 32'({dec_en, exec_en, pc_step, pc_jmp}), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_state", 32'(state_o), 0);
        clr_inputs();
        step_mode = 0;
        sb.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        $display("[TB] reset released");
    endtask

    // Runs one instruction; entered and left at a negedge inside a FETCH cycle
    // (or STOP when stopped=1). wdly = wait cycles before the done cycle.
    task automatic do_instr(input int fdly, input bit h, input bit b, input bit io,
                            input bit j, input int wdly, input int pcyc, output bit stopped);
        exp_t e;
        int   nf;
        int   nw;
        bit   bus_to;
        stopped = 0;
        nf = (fdly >= TO) ? TO : fdly;
        bus_to = b && !h && (wdly >= TO);
        for (int i = 0; i < nf; i++) begin
            mem_ready = 0;
            #1 chk("fetch_wait_req", 32'(fetch_req), 1);
            chk("fetch_wait_ir", 32'(ir_load), 0);
            @(negedge clk);
        end
        if (fdly >= TO) begin
            #1 chk("fetch_to_state", 32'(state_o), 7);
            chk("fetch_to_fault", 32'(fault), 1);
            chk("fetch_to_halted", 32'(halted), 1);
            chk("fetch_to_req", 32'(fetch_req), 0);
            stopped = 1;
            $display("[TB] fetch timeout");
            return;
        end
        mem_ready = 1; is_halt = h; is_bus = b; is_io = io; jmp_taken = j;
        #1 chk("fetch_req", 32'(fetch_req), 1);
        chk("ir_load", 32'(ir_load), 1);
        if (!h && !bus_to) begin
            e.jmp = j; e.cnt = model_cnt;
            sb.push_back(e);
            model_cnt = model_cnt + 1'b1;
        end
        @(negedge clk);
        mem_ready = 0;
        #1 chk("decode_state", 32'(state_o), 1);
        chk("dec_en", 32'({dec_en, exec_en, ir_load}), 3'b100);
        @(negedge clk);
        step = 1'($urandom_range(0, 1));
        #1 chk("exec_state", 32'(state_o), 2);
        chk("exec_en", 32'({dec_en, exec_en}), 2'b01);
        @(negedge clk);
        step = 0;
        if (h) begin
            #1 chk("halt_state", 32'(state_o), 7);
            chk("halt_halted", 32'(halted), 1);
            chk("halt_fault", 32'(fault), 0);
            clr_inputs();
            stopped = 1;
            $display("[TB] halt");
            return;
        end
        if (b || io) begin
            nw = bus_to ? TO : wdly;
            for (int i = 0; i < nw; i++) begin
                #1 chk("wait_state", 32'(state_o), b ? 3 : 4);
                chk("wait_quiet", 32'({exec_en, pc_step, pc_jmp}), 0);
                @(negedge clk);
            end
            if (bus_to) begin
                #1 chk("bus_to_state", 32'(state_o), 7);
                chk("bus_to_fault", 32'(fault), 1);
                chk("bus_to_halted", 32'(halted), 1);
                clr_inputs();
                stopped = 1;
                $display("[TB] bus timeout");
                return;
            end
            #1 chk("done_state", 32'(state_o), b ? 3 : 4);
            if (b) bus_done = 1; else io_done = 1;
            @(negedge clk);
            bus_done = 0; io_done = 0;
        end
        #1 chk("retire_state", 32'(state_o), 5);
        @(negedge clk);
        clr_inputs();
        if (step_mode) begin
            #1 chk("pause_state", 32'(state_o), 6);
            for (int i = 0; i < pcyc; i++) begin
                @(negedge clk);
                #1 chk("pause_hold", 32'(state_o), 6);
                chk("pause_req", 32'(fetch_req), 0);
            end
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) step = 1; else step_mode = 0;
            @(negedge clk);
            step = 0;
        end
        #1 chk("next_fetch_state", 32'(state_o), 0);
        chk("next_fetch_req", 32'(fetch_req), 1);
    endtask

    initial begin : main
        bit st;
        int c0;
        int r, fd, wd;
        bit kb, ki, kh;
        rst = 1; step_mode = 0; model_cnt = 0;
        clr_inputs();
        mem_ready = 1;
        #1;
        chk("por_fetch_req", 32'(fetch_req), 0);
        chk("por_ir_load", 32'(ir_load), 0);
        chk("por_state", 32'(state_o), 0);
        chk("por_retired", 32'(retired), 0);
        chk("por_stop", 32'({halted, fault}), 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Plain instruction: 4 cycles, then fetch again.
        c0 = cyc;
        do_instr(0, 0, 0, 0, 0, 0, 0, st);
        chk("plain_latency", 32'(cyc - c0), 4);
        chk("plain_retired", 32'(retired), 1);

        // Bus instruction with bus_done on the 3rd WAIT_BUS cycle: 7 cycles.
        c0 = cyc;
        do_instr(0, 0, 1, 0, 0, 2, 0, st);
        chk("bus_latency", 32'(cyc - c0), 7);

        // Jump then halt; STOP ignores everything for 20 cycles.
        do_reset();
        do_instr(0, 0, 0, 0, 1, 0, 0, st);
        do_instr(0, 1, 0, 0, 0, 0, 0, st);
        chk("halt_retired", 32'(retired), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1)); bus_done = 1'($urandom_range(0, 1));
            io_done = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
            #1 chk("stop_strobes", 32'({fetch_req, ir_load, dec_en, exec_en, pc_step, pc_jmp}), 0);
            chk("stop_state", 32'({state_o, halted, retired}), {3'd7, 1'b1, 4'd1});
        end
        clr_inputs();

        // Timeout boundaries: ready/done on the last allowed cycle wins.
        do_reset();
        do_instr(TO, 0, 0, 0, 0, 0, 0, st);
        do_reset();
        do_instr(TO - 1, 0, 0, 0, 0, 0, 0, st);
        do_instr(0, 0, 1, 0, 0, TO - 1, 0, st);
        chk("edge_no_fault", 32'({fault, halted}), 0);
        do_instr(0, 0, 0, 1, 0, 20, 0, st);
        do_instr(0, 0, 1, 0, 0, TO, 0, st);

        // Single-step mode.
        do_reset();
        step_mode = 1;
        for (int i = 0; i < 3; i++) begin
            step_mode = 1;
            do_instr(0, 0, i == 1, 0, i == 2, 1, i, st);
        end
        step_mode = 0;

        // Retired counter wraps after 16 retires.
        do_reset();
        for (int i = 0; i < 16; i++) do_instr(0, 0, 0, 0, 0, 0, 0, st);
        chk("retired_wrap", 32'(retired), 0);

        // Reset mid-WAIT_IO aborts with no retire strobe.
        do_instr(0, 0, 0, 0, 0, 0, 0, st);
        mem_ready = 1; is_io = 1;
        @(negedge clk); mem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("io_wait_state", 32'(state_o), 4);
        do_reset();
        #1 chk("post_rst_state", 32'(state_o), 0);
        chk("post_rst_req", 32'(fetch_req), 1);

        // Randomised traffic.
        for (int n = 0; n < 250; n++) begin
            r  = int'($urandom_range(0, 99));
            fd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : 0;
            if (r < 2) fd = TO;
            kh = (r >= 2 && r < 5);
            kb = (r >= 5 && r < 35);
            ki = (r >= 35 && r < 55);
            wd = kb ? ((r < 8) ? TO : int'($urandom_range(0, TO - 1))) : int'($urandom_range(0, 12));
            step_mode = ($urandom_range(0, 4) == 0);
            do_instr(fd, kh, kb, ki, 1'($urandom_range(0, 1)), wd, int'($urandom_range(0, 3)), st);
            if (st) do_reset();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
